// File: rtl/cory_stream_monitor_if.sv
// Valid/ready stream bundle observed by cory_stream_monitor.
// The source uses master, the sink uses slave, and a passive observer uses monitor.
interface cory_stream_monitor_if #(
    parameter int N = 8
);
    logic         v;
    logic [N-1:0] d;
    logic         r;

    modport master  (output v, output d, input  r);
    modport slave   (input  v, input  d, output r);
    modport monitor (input  v, input  d, input  r);
endinterface

// File: rtl/cory_stream_monitor.sv
// Passive valid/ready stream observer: cycle statistics, XOR checksum of
// transferred data, and handshake protocol checks (valid drop, data change while stalled).
module cory_stream_monitor #(
    parameter int N  = 8,
    parameter int CW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    cory_stream_monitor_if.monitor mon,
    input  logic                   i_clr,
    output logic [CW-1:0]          o_xfer_cnt,
    output logic [CW-1:0]          o_stall_cnt,
    output logic [CW-1:0]          o_idle_cnt,
    output logic [N-1:0]           o_last_d,
    output logic [N-1:0]           o_csum,
    output logic                   o_err_drop,
    output logic                   o_err_chg,
    output logic                   o_err
);

    typedef enum logic {
        P_NONE = 1'b0,
        P_HELD = 1'b1
    } pend_t;

    pend_t        pend;
    logic [N-1:0] pend_d;

    logic xfer;
    logic stall;
    logic idle;
    logic viol_drop;
    logic viol_chg;

    always_comb begin
        xfer      = mon.v & mon.r;
        stall     = mon.v & ~mon.r;
        idle      = ~mon.v;
        // Checks look only at valid and data; ready is irrelevant to both rules.
        viol_drop = (pend == P_HELD) & ~mon.v;
        viol_chg  = (pend == P_HELD) & mon.v & (mon.d != pend_d);
    end

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: every register here, including the pending tracker, is reset so that
        // a stall interrupted by reset can never produce an error afterwards.
        if (reset) begin
            pend        <= P_NONE;
            pend_d      <= '0;
            o_xfer_cnt  <= '0;
            o_stall_cnt <= '0;
            o_idle_cnt  <= '0;
            o_last_d    <= '0;
            o_csum      <= '0;
            o_err_drop  <= 1'b0;
            o_err_chg   <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the checks below compare against
            // the pend/pend_d values from the previous cycle.
            pend <= stall ? P_HELD : P_NONE;
            if (stall) begin
                pend_d <= mon.d;
            end

            o_err_drop <= viol_drop;
            o_err_chg  <= viol_chg;

            // A clear discards this cycle's events but leaves the tracker running.
            if (i_clr) begin
                o_xfer_cnt  <= '0;
                o_stall_cnt <= '0;
                o_idle_cnt  <= '0;
                o_last_d    <= '0;
                o_csum      <= '0;
                o_err       <= 1'b0;
            end else begin
                if (xfer) begin
                    o_xfer_cnt <= sat_inc(o_xfer_cnt);
                    o_last_d   <= mon.d;
                    o_csum     <= o_csum ^ mon.d;
                end
                if (stall) begin
                    o_stall_cnt <= sat_inc(o_stall_cnt);
                end
                if (idle) begin
                    o_idle_cnt <= sat_inc(o_idle_cnt);
                end
                if (viol_drop | viol_chg) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cory_stream_monitor.sv
// Self-checking bench for cory_stream_monitor: table-driven stream vectors with a
// scoreboard queue, plus hand-written clear, saturation and reset-mid-stall sequences.
module tb_cory_stream_monitor;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    logic clr;

    always #5 clk = ~clk;

    cory_stream_monitor_if #(.N(N)) s ();

    logic [31:0]  xfer8, stall8, idle8;
    logic [N-1:0] last8, csum8;
    logic         drop8, chg8, err8;
    logic [3:0]   xfer4, stall4, idle4;
    logic [N-1:0] last4, csum4;
    logic         drop4, chg4, err4;

    cory_stream_monitor #(.N(N), .CW(32)) dut (
        .clk(clk), .reset(reset), .mon(s), .i_clr(clr),
        .o_xfer_cnt(xfer8), .o_stall_cnt(stall8), .o_idle_cnt(idle8),
        .o_last_d(last8), .o_csum(csum8),
        .o_err_drop(drop8), .o_err_chg(chg8), .o_err(err8)
    );

    cory_stream_monitor #(.N(N), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .mon(s), .i_clr(clr),
        .o_xfer_cnt(xfer4), .o_stall_cnt(stall4), .o_idle_cnt(idle4),
        .o_last_d(last4), .o_csum(csum4),
        .o_err_drop(drop4), .o_err_chg(chg4), .o_err(err4)
    );

    typedef struct {
        logic         v;
        logic [N-1:0] d;
        logic         r;
        logic         clr;
        logic         drop;
        logic         chg;
    } vec_t;

    typedef struct {
        logic [31:0]  xfer;
        logic [31:0]  stall;
        logic [31:0]  idle;
        logic [3:0]   xfer4;
        logic [N-1:0] last;
        logic [N-1:0] csum;
        logic         drop;
        logic         chg;
        logic         err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    logic [31:0]  m_xfer, m_stall, m_idle;
    logic [3:0]   m_xfer4;
    logic [N-1:0] m_last, m_csum;
    logic         m_err;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_xfer = '0; m_stall = '0; m_idle = '0; m_xfer4 = '0;
        m_last = '0; m_csum = '0; m_err = 1'b0;
    endtask

    // Drive one cycle, predict the outputs after the edge, then compare.
    task automatic step(input logic v, input logic [N-1:0] d, input logic r,
                        input logic c, input logic edrop, input logic echg);
        exp_t e;
        exp_t got;
        s.v = v; s.d = d; s.r = r; clr = c;
        if (c) begin
            model_clear();
        end else begin
            if (v && r) begin
                m_xfer = m_xfer + 1;
                if (m_xfer4 != 4'hF) m_xfer4 = m_xfer4 + 1;
                m_last = d;
                m_csum = m_csum ^ d;
            end else if (v) begin
                m_stall = m_stall + 1;
            end else begin
                m_idle = m_idle + 1;
            end
            m_err = m_err | edrop | echg;
        end
        e.xfer = m_xfer; e.stall = m_stall; e.idle = m_idle; e.xfer4 = m_xfer4;
        e.last = m_last; e.csum = m_csum; e.drop = edrop; e.chg = echg; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("xfer_cnt",  64'(xfer8),  64'(got.xfer));
        check("stall_cnt", 64'(stall8), 64'(got.stall));
        check("idle_cnt",  64'(idle8),  64'(got.idle));
        check("xfer_cnt4", 64'(xfer4),  64'(got.xfer4));
        check("last_d",    64'(last8),  64'(got.last));
        check("csum",      64'(csum8),  64'(got.csum));
        check("err_drop",  64'(drop8),  64'(got.drop));
        check("err_chg",   64'(chg8),   64'(got.chg));
        check("err",       64'(err8),   64'(got.err));
    endtask

    task automatic apply_reset();
        reset = 1'b1; s.v = 1'b0; s.d = '0; s.r = 1'b0; clr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xfer"},  64'(xfer8),  64'd0);
        check({tag, "_stall"}, 64'(stall8), 64'd0);
        check({tag, "_idle"},  64'(idle8),  64'd0);
        check({tag, "_last"},  64'(last8),  64'd0);
        check({tag, "_csum"},  64'(csum8),  64'd0);
        check({tag, "_err"},   64'(err8),   64'd0);
        check({tag, "_drop"},  64'(drop8),  64'd0);
        check({tag, "_chg"},   64'(chg8),   64'd0);
    endtask

    initial begin
        // stall/accept; data change while stalled; drop with ready high; change on accepting cycle
        vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h5B, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h5B, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

        apply_reset();
        check_all_zero("reset");

        // Three back-to-back transfers.
        step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq1_xfer", 64'(xfer8), 64'd3);
        check("seq1_last", 64'(last8), 64'h44);
        check("seq1_csum", 64'(csum8), 64'h77);
        check("seq1_err",  64'(err8),  64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].clr, vecs[i].drop, vecs[i].chg);
        end
        check("sticky_err", 64'(err8), 64'd1);

        // Clear wipes statistics and the sticky flag.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all_zero("clear");

        // Violation in the clear cycle still pulses, but the sticky flag stays low.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_viol_err", 64'(err8), 64'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, N'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check("sat_xfer4", 64'(xfer4), 64'd15);
        check("sat_xfer8", 64'(xfer8), 64'd20);

        // Transfer coincident with clear is discarded.
        step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_xfer4", 64'(xfer4), 64'd0);
        check("clr_xfer8", 64'(xfer8), 64'd0);
        check("clr_last",  64'(last8), 64'd0);

        // Reset in the middle of a stall drops the pending state.
        step(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        apply_reset();
        check_all_zero("rst_stall");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_drop", 64'(drop8), 64'd0);
        check("post_rst_err",  64'(err8),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cory_stream_monitor.md
Name: cory_stream_monitor

Overview:
- Passive observer for one valid/ready stream, e.g. the output of cory_s2s.
- Counts transfer, stall and idle cycles and keeps a running XOR checksum of the transferred data.
- Checks handshake protocol rules and raises pulse and sticky error flags.
- Drives nothing back onto the observed stream.

Parameters:
- N, 8, observed data width in bits (minimum 1).
- CW, 32, width of each statistics counter (minimum 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_v  input  1  observed valid.
- i_d  input  N  observed data.
- i_r  input  1  observed ready.
- i_clr  input  1  synchronous clear of statistics and sticky errors.
- o_xfer_cnt  output  CW  cycles with i_v & i_r.
- o_stall_cnt  output  CW  cycles with i_v & !i_r.
- o_idle_cnt  output  CW  cycles with !i_v.
- o_last_d  output  N  data of the most recent transfer.
- o_csum  output  N  XOR of all transferred data words.
- o_err_drop  output  1  one-cycle pulse: valid withdrawn before acceptance.
- o_err_chg  output  1  one-cycle pulse: data changed while stalled.
- o_err  output  1  sticky OR of both error pulses.

Behaviour:
- Classification, evaluated each cycle: xfer = i_v & i_r; stall = i_v & !i_r; idle = !i_v.
  - i_r high while i_v low is legal and counts as idle.
- Reset (reset=1 at a clock edge) zeroes every output and register, including pending state. No counting occurs in a reset cycle.
- Counters: the matching counter increments by 1 per classified cycle. Each counter saturates at all-ones and does not wrap.
- On xfer: o_last_d <= i_d and o_csum <= o_csum ^ i_d. Both are registered, visible the cycle after the transfer.
- Pending tracker (internal): a stall cycle sets pend=1 and captures pend_d=i_d.
  - Any xfer or idle cycle clears pend.
  - A stall while pend=1 keeps pend set and recaptures pend_d.
- Protocol checks, evaluated in a cycle where pend=1 (i.e. the previous cycle was a stall):
  - i_v=0: o_err_drop=1 for exactly one cycle, registered, asserted the cycle after the violation.
  - i_v=1 and i_d != pend_d: o_err_chg=1 for one cycle, same timing.
  - These two conditions are mutually exclusive in any one cycle.
  - Checks do not depend on i_r; a changed-data transfer that ends a stall is still flagged.
- o_err: set whenever either error pulse would be set. Held until reset or i_clr.
- i_clr=1:
  - Next cycle, all three counters, o_csum, o_last_d and o_err are 0.
  - Events in the i_clr cycle are discarded (clear wins).
  - Error pulses for a violation in the clear cycle still fire, but o_err stays 0.
  - The pending tracker is not cleared by i_clr, so protocol checks continue across a clear.
- Reset mid-stall: pend is dropped; no error is reported for the stall in progress.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 3 transfers with i_d = 0x11, 0x22, 0x44, i_r held high.
  - xfer_cnt=3, stall=0, idle=0, last_d=0x44, csum=0x77, err=0.
- i_v=1, i_d=0x5A, i_r=0 for 2 cycles, then i_r=1.
  - stall_cnt=2, xfer_cnt=1, no error pulses, last_d=0x5A.
- Stall with 0x5A, then i_d=0x5B the next cycle while still stalled.
  - o_err_chg pulses exactly one cycle; o_err stays 1 afterwards.
- Stall one cycle, then drop i_v.
  - o_err_drop pulses once, o_err=1, idle_cnt increments.
  - Then i_clr=1 for one cycle: all counters, csum, last_d and err are 0 on the next cycle.
- CW=4: 20 consecutive transfers -> xfer_cnt holds at 15 (no wrap). Simultaneous i_clr with a transfer -> the transfer is not counted.
- Assert reset during a stall, release, then idle -> no error pulse, all outputs 0.
